// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundle between the ID/EX pipeline registers and the hazard controller.
//   master: pipeline side, drives ID/EX status and receives the controls.
//   slave : hazard controller.
//   ID status : id_valid, id_rs1, id_rs2, id_rs2_use, id_jump, id_is_jr, id_hlt
//   EX status : ex_valid, ex_mem_rd, ex_reg_wr, ex_rd, ex_br_taken
//   Controls  : pc_stall, ifid_stall, ifid_flush, idex_bubble, halted
//   Perf      : stall_cnt, flush_cnt (CNT_W bits, saturating)
//   Handshake: no valid/ready pair. id_valid / ex_valid qualify their stage
//   contents every cycle, and the controls act on the next rising edge.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs2_use;
  logic             id_jump;
  logic             id_is_jr;
  logic             id_hlt;
  logic             ex_valid;
  logic             ex_mem_rd;
  logic             ex_reg_wr;
  logic [4:0]       ex_rd;
  logic             ex_br_taken;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs2_use, id_jump, id_is_jr, id_hlt,
    output ex_valid, ex_mem_rd, ex_reg_wr, ex_rd, ex_br_taken,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, halted,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs2_use, id_jump, id_is_jr, id_hlt,
    input  ex_valid, ex_mem_rd, ex_reg_wr, ex_rd, ex_br_taken,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, halted,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard controller of the pipelined MIPS32 core. It drives stall, flush
//   and bubble for IF/ID/EX from the ID instruction's decoded controls and
//   the EX-stage state. HLT is handled as drain-then-halt. Saturating perf
//   counters track stall cycles and flush events.
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   hz        : slave modport of pipeline_hazard_ctrl_if (status in, controls out)
//   dbg_state : current FSM state (0 RUN, 1 DRAIN, 2 HALTED)
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz,
  output logic [1:0]             dbg_state
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [DW-1:0]    drain_cnt;
  logic             halted_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic lu, jr, jf, hlt_req;
  logic pc_stall, ifid_stall, ifid_flush, idex_bubble;
  logic stall_inc, flush_inc;

  // Hazard terms. r0 is never a real destination, so it never hazards.
  always_comb begin
    lu = hz.id_valid & hz.ex_valid & hz.ex_mem_rd & (hz.ex_rd != 5'd0) &
         ((hz.ex_rd == hz.id_rs1) | (hz.id_rs2_use & (hz.ex_rd == hz.id_rs2)));
    jr = hz.id_valid & hz.id_is_jr & hz.ex_valid & hz.ex_reg_wr &
         (hz.ex_rd != 5'd0) & (hz.ex_rd == hz.id_rs1);
    jf      = hz.id_valid & (hz.id_jump | hz.id_is_jr) & ~lu & ~jr;
    hlt_req = hz.id_valid & hz.id_hlt;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // Next-state logic. A taken branch or a pending stall outranks HLT,
  // so HLT is only accepted once it is the oldest unresolved item in ID.
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (~hz.ex_br_taken & ~(lu | jr) & hlt_req) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nx = HALTED;
      HALTED:  state_nx = HALTED;
      default: state_nx = RUN;
    endcase
  end

  // Output logic. Everything is forced low while rst is asserted.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (hz.ex_br_taken) begin
            // ID holds a wrong-path instruction: kill it, whatever it is.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
          end else if (lu | jr) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
          end else if (hlt_req) begin
            // HLT itself flows into EX as a NOP, so no bubble here.
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
          end else if (jf) begin
            ifid_flush  = 1'b1;
            flush_inc   = 1'b1;
          end
        end
        DRAIN, HALTED: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Drain counter, halted flag and saturating perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt   <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      halted_q <= (state_nx == HALTED);
      if (state == RUN && state_nx == DRAIN) drain_cnt <= '0;
      else if (state == DRAIN)               drain_cnt <= drain_cnt + DW'(1);
      if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.pc_stall    = pc_stall;
  assign hz.ifid_stall  = ifid_stall;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.halted      = halted_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Self-checking bench for pipeline_hazard_ctrl: a vector table for the
//   single-cycle hazard cases plus hand-written HLT/drain, reset and
//   counter-saturation sequences. Control outputs are checked through an
//   expected queue; perf counters are checked against a bench-side model.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int NV    = 19;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz_if ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (hz_if),
    .dbg_state (dbg_state)
  );

  // ---------------- vectors ----------------
  // exp bit order: {pc_stall, ifid_stall, ifid_flush, idex_bubble}
  typedef struct {
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs2_use;
    logic       jump;
    logic       is_jr;
    logic       hlt;
    logic       ex_valid;
    logic       ex_mem_rd;
    logic       ex_reg_wr;
    logic [4:0] ex_rd;
    logic       br;
    logic [3:0] exp;
    logic       s_inc;
    logic       f_inc;
  } vec_t;

  vec_t vecs[NV];

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0]       exp_q[$];
  logic [CNT_W-1:0] m_stall, m_flush;

  function automatic vec_t mk(
    input logic iv, input logic [4:0] r1, input logic [4:0] r2, input logic use2,
    input logic j, input logic jrr, input logic h,
    input logic ev, input logic lmem, input logic wr, input logic [4:0] rd,
    input logic b, input logic [3:0] e, input logic si, input logic fi);
    vec_t v;
    v.id_valid = iv; v.rs1 = r1; v.rs2 = r2; v.rs2_use = use2;
    v.jump = j; v.is_jr = jrr; v.hlt = h;
    v.ex_valid = ev; v.ex_mem_rd = lmem; v.ex_reg_wr = wr; v.ex_rd = rd;
    v.br = b; v.exp = e; v.s_inc = si; v.f_inc = fi;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    hz_if.id_valid    = v.id_valid;
    hz_if.id_rs1      = v.rs1;
    hz_if.id_rs2      = v.rs2;
    hz_if.id_rs2_use  = v.rs2_use;
    hz_if.id_jump     = v.jump;
    hz_if.id_is_jr    = v.is_jr;
    hz_if.id_hlt      = v.hlt;
    hz_if.ex_valid    = v.ex_valid;
    hz_if.ex_mem_rd   = v.ex_mem_rd;
    hz_if.ex_reg_wr   = v.ex_reg_wr;
    hz_if.ex_rd       = v.ex_rd;
    hz_if.ex_br_taken = v.br;
  endtask

  function automatic logic [3:0] ctl();
    return {hz_if.pc_stall, hz_if.ifid_stall, hz_if.ifid_flush, hz_if.idex_bubble};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && c != {CNT_W{1'b1}}) return c + 1'b1;
    return c;
  endfunction

  // One RUN-state cycle: called just after a rising edge, returns just after the next.
  task automatic step(input vec_t v, input string nm);
    logic [3:0] e;
    drive(v);
    exp_q.push_back(v.exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check({nm, " ctl"}, 32'(ctl()), 32'(e));
    check({nm, " stall_cnt"}, 32'(hz_if.stall_cnt), 32'(m_stall));
    check({nm, " flush_cnt"}, 32'(hz_if.flush_cnt), 32'(m_flush));
    @(posedge clk); #1;
    m_stall = sat_inc(m_stall, v.s_inc);
    m_flush = sat_inc(m_flush, v.f_inc);
  endtask

  // Reset for one cycle while v is driven; outputs must stay low throughout.
  task automatic do_reset(input vec_t v, input string nm);
    rst = 1'b1;
    drive(v);
    @(negedge clk);
    check({nm, " ctl in rst"}, 32'(ctl()), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_stall = '0;
    m_flush = '0;
    drive(vecs[0]);
    @(negedge clk);
    check({nm, " state after rst"}, 32'(dbg_state), 32'd0);
    check({nm, " halted after rst"}, 32'(hz_if.halted), 32'd0);
    check({nm, " stall_cnt after rst"}, 32'(hz_if.stall_cnt), 32'd0);
    check({nm, " flush_cnt after rst"}, 32'(hz_if.flush_cnt), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t hlt_v, drain_v, lu_v;
    //            iv rs1 rs2 u2 j  jr h  ev ld wr rd  br exp      s  f
    vecs[0]  = mk(0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 4'b0000, 0, 0); // idle
    vecs[1]  = mk(1, 8,  3,  1, 0, 0, 0, 1, 1, 1, 8,  0, 4'b1101, 1, 0); // lw r8; add r8
    vecs[2]  = mk(1, 8,  3,  1, 0, 0, 0, 0, 0, 0, 0,  0, 4'b0000, 0, 0); // bubble in EX
    vecs[3]  = mk(1, 4,  9,  0, 0, 0, 0, 1, 1, 1, 9,  0, 4'b0000, 0, 0); // sw rs2 unused
    vecs[4]  = mk(1, 4,  9,  1, 0, 0, 0, 1, 1, 1, 9,  0, 4'b1101, 1, 0); // rs2 used
    vecs[5]  = mk(1, 0,  0,  1, 0, 0, 0, 1, 1, 1, 0,  0, 4'b0000, 0, 0); // r0 never
    vecs[6]  = mk(0, 8,  8,  1, 0, 0, 0, 1, 1, 1, 8,  0, 4'b0000, 0, 0); // ID invalid
    vecs[7]  = mk(1, 8,  8,  1, 0, 0, 0, 0, 1, 1, 8,  0, 4'b0000, 0, 0); // EX invalid
    vecs[8]  = mk(1, 8,  2,  1, 0, 0, 1, 1, 1, 1, 8,  1, 4'b0011, 0, 1); // br beats lu+hlt
    vecs[9]  = mk(1, 1,  2,  0, 1, 0, 0, 0, 0, 0, 0,  0, 4'b0010, 0, 1); // j
    vecs[10] = mk(1, 31, 0,  0, 0, 1, 0, 1, 0, 1, 31, 0, 4'b1101, 1, 0); // jr r31, EX writes r31
    vecs[11] = mk(1, 31, 0,  0, 0, 1, 0, 0, 0, 0, 0,  0, 4'b0010, 0, 1); // jr proceeds
    vecs[12] = mk(1, 5,  0,  0, 0, 1, 0, 1, 1, 1, 5,  0, 4'b1101, 1, 0); // jr after lw
    vecs[13] = mk(1, 5,  0,  0, 0, 1, 0, 1, 0, 1, 6,  0, 4'b0010, 0, 1); // jr, other rd
    vecs[14] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 4'b0011, 0, 1); // br alone
    vecs[15] = mk(1, 7,  7,  1, 0, 0, 0, 1, 0, 1, 7,  0, 4'b0000, 0, 0); // alu->alu forwarded
    vecs[16] = mk(1, 8,  0,  0, 1, 0, 0, 1, 1, 1, 8,  0, 4'b1101, 1, 0); // lu masks jump
    vecs[17] = mk(1, 8,  0,  0, 0, 0, 1, 1, 1, 1, 8,  0, 4'b1101, 1, 0); // lu holds off hlt
    vecs[18] = mk(1, 3,  4,  1, 0, 1, 0, 1, 0, 0, 3,  0, 4'b0010, 0, 1); // jr, EX no write

    m_stall = '0;
    m_flush = '0;
    drive(vecs[1]);
    rst = 1'b1;

    // Reset state: hazard present on inputs but rst forces controls low
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset ctl", 32'(ctl()), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(vecs[0]);
    @(negedge clk);
    check("reset state", 32'(dbg_state), 32'd0);
    check("reset halted", 32'(hz_if.halted), 32'd0);
    check("reset stall_cnt", 32'(hz_if.stall_cnt), 32'd0);
    check("reset flush_cnt", 32'(hz_if.flush_cnt), 32'd0);
    @(posedge clk); #1;

    // Table vectors, then a randomly ordered replay of the same table
    for (int i = 0; i < NV; i++) step(vecs[i], $sformatf("vec%0d", i));
    for (int k = 0; k < 30; k++) begin
      int idx;
      idx = $urandom_range(0, NV - 1);
      step(vecs[idx], $sformatf("rnd vec%0d", idx));
    end
    check("run state", 32'(dbg_state), 32'd0);

    // HLT: accept, 3 cycles DRAIN (branch ignored), then HALTED and holds
    hlt_v   = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b1100, 0, 0);
    drain_v = mk(1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 4'b1101, 0, 0);
    step(hlt_v, "hlt accept");
    drive(drain_v);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("drain%0d ctl", c), 32'(ctl()), 32'(4'b1101));
      check($sformatf("drain%0d state", c), 32'(dbg_state), 32'd1);
      check($sformatf("drain%0d halted", c), 32'(hz_if.halted), 32'd0);
      @(posedge clk); #1;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("halted%0d ctl", c), 32'(ctl()), 32'(4'b1101));
      check($sformatf("halted%0d state", c), 32'(dbg_state), 32'd2);
      check($sformatf("halted%0d halted", c), 32'(hz_if.halted), 32'd1);
      check($sformatf("halted%0d flush_cnt", c), 32'(hz_if.flush_cnt), 32'(m_flush));
      check($sformatf("halted%0d stall_cnt", c), 32'(hz_if.stall_cnt), 32'(m_stall));
      @(posedge clk); #1;
    end
    do_reset(drain_v, "rst from halted");

    // Saturation: hold a load-use hazard for 2^CNT_W+5 cycles
    lu_v = vecs[1];
    drive(lu_v);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("stall_cnt near top", 32'(hz_if.stall_cnt), 32'hFFFE);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("stall_cnt saturated", 32'(hz_if.stall_cnt), 32'hFFFF);
    check("sat ctl", 32'(ctl()), 32'(4'b1101));
    check("sat flush_cnt", 32'(hz_if.flush_cnt), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of DRAIN
    m_stall = 16'hFFFF;
    step(hlt_v, "hlt accept 2");
    drive(drain_v);
    @(negedge clk);
    check("drain2 state", 32'(dbg_state), 32'd1);
    @(posedge clk); #1;
    do_reset(drain_v, "rst in drain");
    step(vecs[9], "j after rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
